// File: rtl/result_collector.sv
// Captures each tracked result of the (a*b + c) - d*e pipeline exactly once into a
// small FIFO, presents it on valid/ready, and issues credits so no result is lost.
module result_collector #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         load,
  input  logic                         issue,
  input  logic [WIDTH-1:0]             res,
  output logic                         issue_ok,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [LATENCY-1:0] tag;
  logic               fresh;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [LW-1:0]      reserved;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic acc;
  logic push;
  logic pop;
  logic illegal;

  // Credit is decoded from registered state only; a pop frees a slot one edge later.
  always_comb begin
    issue_ok  = (reserved < LW'(DEPTH));
    out_valid = (level != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    acc       = issue & load & issue_ok;
    illegal   = issue & load & ~issue_ok;
    push      = tag[LATENCY-1] & fresh;
    pop       = out_valid & out_ready;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tag      <= '0;
      fresh    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      reserved <= '0;
      overflow <= 1'b0;
    end else begin
      // fresh marks that tag[LATENCY-1] has not yet been captured since the last advance.
      if (load) begin
        tag   <= {tag[LATENCY-2:0], acc};
        fresh <= 1'b1;
      end else if (push) begin
        fresh <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      case ({acc, pop})
        2'b10:   reserved <= reserved + LW'(1);
        2'b01:   reserved <= reserved - LW'(1);
        default: reserved <= reserved;
      endcase

      if (illegal) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res;
  end

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: drives a behavioural 4-stage pipeline and checks the
// collector against a queue-based model of issued, in-flight and buffered results.
module tb_result_collector;

  logic       clk = 1'b0;
  logic       clear;
  logic       load;
  logic       issue;
  logic       out_ready;
  logic [2:0] res;
  logic       issue_ok;
  logic       out_valid;
  logic [2:0] out_data;
  logic [2:0] level;
  logic       overflow;
  logic [2:0] a, b, c, d, e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_collector #(.WIDTH(3), .LATENCY(4), .DEPTH(4)) dut (
    .clk(clk), .clear(clear), .load(load), .issue(issue), .res(res),
    .issue_ok(issue_ok), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow)
  );

  function automatic logic [2:0] calc(input logic [2:0] a_, b_, c_, d_, e_);
    return 3'((a_ * b_ + c_) - d_ * e_);
  endfunction

  // Upstream arithmetic pipeline: operands captured on a load edge appear on res after 4 loads.
  logic [2:0] pipe [4];
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < 4; k++) pipe[k] <= '0;
    end else if (load) begin
      pipe[0] <= calc(a, b, c, d, e);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign res = pipe[3];

  // Reference model: buffered results, plus tracked results with their load-edge age.
  logic [2:0] exp_q [$];
  int         inf_age [$];
  logic [2:0] inf_val [$];
  bit         inf_done [$];
  bit         m_ovf = 1'b0;
  int         m_pend;
  bit         m_ok, m_acc, m_pop;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      exp_q.delete(); inf_age.delete(); inf_val.delete(); inf_done.delete();
      m_ovf = 1'b0;
    end else begin
      m_pend = 0;
      foreach (inf_done[i]) if (!inf_done[i]) m_pend++;
      m_ok  = (exp_q.size() + m_pend) < 4;
      m_acc = issue && load && m_ok;
      if (issue && load && !m_ok) m_ovf = 1'b1;
      m_pop = (exp_q.size() != 0) && out_ready;
      if (m_pop) void'(exp_q.pop_front());
      foreach (inf_age[i]) begin
        if (inf_age[i] == 4 && !inf_done[i]) begin
          exp_q.push_back(inf_val[i]);
          inf_done[i] = 1'b1;
        end
      end
      if (load) begin
        foreach (inf_age[i]) inf_age[i]++;
        for (int i = inf_age.size() - 1; i >= 0; i--) begin
          if (inf_age[i] > 4) begin
            inf_age.delete(i); inf_val.delete(i); inf_done.delete(i);
          end
        end
      end
      if (m_acc) begin
        inf_age.push_back(1);
        inf_val.push_back(calc(a, b, c, d, e));
        inf_done.push_back(1'b0);
      end
    end
  end

  // {out_valid, out_data, level, issue_ok, overflow}
  function automatic logic [8:0] exp_vec();
    int p = 0;
    int lvl = exp_q.size();
    foreach (inf_done[i]) if (!inf_done[i]) p++;
    return {lvl != 0, (lvl != 0) ? exp_q[0] : 3'd0, 3'(lvl), (lvl + p) < 4, m_ovf};
  endfunction

  logic [8:0] dvec;
  assign dvec = {out_valid, out_data, level, issue_ok, overflow};
  localparam logic [8:0] RESET_VEC = 9'b0_000_000_1_0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_ops();
    a = 3'($urandom); b = 3'($urandom); c = 3'($urandom);
    d = 3'($urandom); e = 3'($urandom);
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if (dvec !== RESET_VEC) begin
      errors++; $display("FAIL reset_held got %b exp %b", dvec, RESET_VEC);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (dvec !== RESET_VEC || dvec !== exp_vec()) begin
      errors++; $display("FAIL reset_release got %b exp %b", dvec, RESET_VEC);
    end
  endtask

  task automatic test_single();
    a = 3'd2; b = 3'd3; c = 3'd1; d = 3'd1; e = 3'd2;
    issue = 1'b1; load = 1'b1; out_ready = 1'b1;
    tick();
    issue = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      rand_ops();
      tick();
      checks++;
      if (dvec !== exp_vec()) begin
        errors++; $display("FAIL single cyc %0d got %b exp %b", cyc, dvec, exp_vec());
      end
      checks++;
      if (out_valid !== (cyc == 4) || (cyc == 4 && out_data !== 3'd5)) begin
        errors++; $display("FAIL single_timing cyc %0d valid %b data %0d exp valid %b data 5",
                           cyc, out_valid, out_data, cyc == 4);
      end
    end
  endtask

  task automatic test_stall();
    a = 3'd2; b = 3'd3; c = 3'd1; d = 3'd1; e = 3'd2;
    issue = 1'b1; load = 1'b1; out_ready = 1'b0;
    tick();
    issue = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_ops(); tick(); end
    load = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      checks++;
      if (dvec !== exp_vec() || level !== 3'd1 || out_data !== 3'd5) begin
        errors++; $display("FAIL stall cyc %0d got %b exp %b level 1 data 5", cyc, dvec, exp_vec());
      end
    end
    load = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      rand_ops(); tick();
      checks++;
      if (dvec !== exp_vec() || level !== 3'd1) begin
        errors++; $display("FAIL stall_resume cyc %0d got %b exp %b", cyc, dvec, exp_vec());
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (dvec !== exp_vec() || level !== 3'd0) begin
      errors++; $display("FAIL stall_drain got %b exp %b", dvec, exp_vec());
    end
  endtask

  task automatic test_fill_overflow();
    a = 3'd7; b = 3'd7; c = 3'd2; d = 3'd2; e = 3'd3;
    issue = 1'b1; load = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (issue_ok !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL fill_credit issue_ok %b overflow %b exp 0 0", issue_ok, overflow);
    end
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL fill_overflow got %b exp 1", overflow);
    end
    issue = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_ops(); tick(); end
    checks++;
    if (dvec !== exp_vec() || level !== 3'd4 || out_data !== 3'd5 || issue_ok !== 1'b0) begin
      errors++; $display("FAIL fill_full got %b exp %b", dvec, exp_vec());
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 3'd5) begin
        errors++; $display("FAIL drain %0d valid %b data %0d exp 1 5", i, out_valid, out_data);
      end
      tick();
    end
    checks++;
    if (dvec !== exp_vec() || level !== 3'd0 || issue_ok !== 1'b1) begin
      errors++; $display("FAIL drain_done got %b exp %b", dvec, exp_vec());
    end
  endtask

  task automatic test_stream();
    issue = 1'b1; load = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      rand_ops(); tick();
      checks++;
      if (dvec !== exp_vec() || level > 3'd1) begin
        errors++; $display("FAIL stream cyc %0d got %b exp %b", cyc, dvec, exp_vec());
      end
    end
    issue = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin rand_ops(); tick(); end
  endtask

  task automatic test_clear_midflight();
    bit pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    load = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue = pattern[i]; rand_ops(); tick();
    end
    issue = 1'b0;
    checks++;
    if (dvec !== exp_vec() || level !== 3'd1) begin
      errors++; $display("FAIL preclear got %b exp %b", dvec, exp_vec());
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (dvec !== RESET_VEC || dvec !== exp_vec()) begin
      errors++; $display("FAIL async_clear got %b exp %b", dvec, RESET_VEC);
    end
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      rand_ops(); tick();
      checks++;
      if (dvec !== RESET_VEC) begin
        errors++; $display("FAIL postclear cyc %0d got %b exp %b", cyc, dvec, RESET_VEC);
      end
    end
  endtask

  task automatic test_load_low_issue();
    issue = 1'b1; load = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      rand_ops(); tick();
      checks++;
      if (dvec !== RESET_VEC) begin
        errors++; $display("FAIL loadlow cyc %0d got %b exp %b", cyc, dvec, RESET_VEC);
      end
    end
    issue = 1'b0; load = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      rand_ops(); tick();
      checks++;
      if (dvec !== RESET_VEC) begin
        errors++; $display("FAIL loadlow_after cyc %0d got %b exp %b", cyc, dvec, RESET_VEC);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      issue     = ($urandom_range(0, 99) < 60);
      load      = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 50);
      rand_ops(); tick();
      checks++;
      if (dvec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %b exp %b", cyc, dvec, exp_vec());
      end
    end
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; issue = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0;
    test_reset();
    test_single();
    test_stall();
    test_fill_overflow();
    test_stream();
    test_clear_midflight();
    test_load_low_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
